// File: rtl/input_conditioner.sv
// Per-bit synchronizer, debouncer and rise/fall edge detector for raw tile pins.
// Each bit is conditioned independently; all state is reset synchronously.
module input_conditioner #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [CntW-1:0]  cnt_q  [WIDTH];
  logic [CntW-1:0]  cnt_d  [WIDTH];
  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  // A level is accepted only after DEBOUNCE_CYCLES consecutive enabled mismatches;
  // any cycle where s agrees with dout discards the partial count.
  always_comb begin
    dout_d = dout;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == dout[i]) begin
        cnt_d[i] = '0;
      end else if (en) begin
        if (cnt_q[i] == CntLast) begin
          cnt_d[i]  = '0;
          dout_d[i] = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      dout    <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      cnt_q   <= cnt_d;
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
      changed <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: a D=4 and a D=1 conditioner share stimulus and are compared
// against a per-bit behavioural model of synchronise-then-debounce.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic [7:0] dout4, rise4, fall4;
  logic       changed4;
  logic [7:0] dout1, rise1, fall1;
  logic       changed1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]      h0;
    logic [7:0]      h1;
    logic [7:0]      dout;
    logic [7:0]      rise;
    logic [7:0]      fall;
    logic            changed;
    logic [7:0][7:0] run;
  } mstate_t;

  mstate_t m4, m1;

  always #5 clk = ~clk;

  input_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout4), .rise(rise4), .fall(fall4), .changed(changed4)
  );

  input_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout1), .rise(rise1), .fall(fall1), .changed(changed1)
  );

  // Model: the pin is seen two edges late; a bit flips once it has disagreed with
  // the clean level for d enabled cycles in a row (agreement wipes the run).
  task automatic model_step(input int d, input logic r, input logic e, input logic [7:0] x,
                            inout mstate_t m);
    logic [7:0] seen;
    if (r) begin
      m = '0;
      return;
    end
    seen   = m.h1;
    m.rise = '0;
    m.fall = '0;
    for (int i = 0; i < 8; i++) begin
      if (seen[i] == m.dout[i]) begin
        m.run[i] = 8'd0;
      end else if (e) begin
        m.run[i] = m.run[i] + 8'd1;
        if (int'(m.run[i]) == d) begin
          m.dout[i] = seen[i];
          if (seen[i]) m.rise[i] = 1'b1;
          else         m.fall[i] = 1'b1;
          m.run[i] = 8'd0;
        end
      end
    end
    m.changed = (m.rise != 8'h00) || (m.fall != 8'h00);
    m.h1 = m.h0;
    m.h0 = x;
  endtask

  task automatic step();
    @(posedge clk);
    model_step(4, rst, en, din, m4);
    model_step(1, rst, en, din, m1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; din = 8'h00;
    step(); step();
    checks++;
    if ({dout4, rise4, fall4, changed4, dout1, rise1, fall1, changed1} !== '0) begin
      errors++;
      $display("FAIL reset: dout4=%h rise4=%h fall4=%h chg4=%b dout1=%h expected all zero",
               dout4, rise4, fall4, changed4, dout1);
    end
    rst = 1'b0;
  endtask

  task automatic test_rise();
    din = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (dout4 !== (k >= 6 ? 8'h01 : 8'h00) || rise4 !== (k == 6 ? 8'h01 : 8'h00) ||
          fall4 !== 8'h00 || changed4 !== (k == 6)) begin
        errors++;
        $display("FAIL rise edge%0d: dout=%h rise=%h fall=%h chg=%b", k, dout4, rise4, fall4,
                 changed4);
      end
      checks++;
      if ({dout1, rise1, fall1, changed1} !== {m1.dout, m1.rise, m1.fall, m1.changed}) begin
        errors++;
        $display("FAIL rise_d1 edge%0d: dout=%h rise=%h expected dout=%h rise=%h", k, dout1,
                 rise1, m1.dout, m1.rise);
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      din = (k <= 3) ? 8'h09 : 8'h01;
      step();
      checks++;
      if (dout4 !== 8'h01 || rise4 !== 8'h00 || fall4 !== 8'h00 || changed4 !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc%0d: dout=%h rise=%h fall=%h expected dout=01 no strobes", k,
                 dout4, rise4, fall4);
      end
    end
    din = 8'h09;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (rise4 === 8'h08) pulses++;
      checks++;
      if ({dout1, rise1, fall1, changed1} !== {m1.dout, m1.rise, m1.fall, m1.changed}) begin
        errors++;
        $display("FAIL glitch_d1 cyc%0d: dout=%h rise=%h expected dout=%h rise=%h", k, dout1,
                 rise1, m1.dout, m1.rise);
      end
    end
    checks++;
    if (pulses != 1 || dout4 !== 8'h09) begin
      errors++;
      $display("FAIL glitch_hold: rise3 pulses=%0d dout=%h expected 1 pulse dout=09", pulses,
               dout4);
    end
  endtask

  task automatic test_multi();
    din = 8'hFF;
    repeat (8) step();
    checks++;
    if (dout4 !== 8'hFF) begin
      errors++;
      $display("FAIL settle_ff: dout=%h expected ff", dout4);
    end
    din = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (dout4 !== (k >= 6 ? 8'hA5 : 8'hFF) || fall4 !== (k == 6 ? 8'h5A : 8'h00) ||
          rise4 !== 8'h00 || changed4 !== (k == 6)) begin
        errors++;
        $display("FAIL multi edge%0d: dout=%h rise=%h fall=%h chg=%b", k, dout4, rise4, fall4,
                 changed4);
      end
    end
  endtask

  task automatic test_enable();
    logic [5:0] seq = 6'b111001;
    en = 1'b0; din = 8'hA4;
    repeat (3) step();
    for (int k = 0; k < 6; k++) begin
      en = seq[k];
      step();
      checks++;
      if (dout4 !== (k == 5 ? 8'hA4 : 8'hA5) || fall4 !== (k == 5 ? 8'h01 : 8'h00) ||
          rise4 !== 8'h00) begin
        errors++;
        $display("FAIL enable step%0d: dout=%h fall=%h rise=%h", k, dout4, fall4, rise4);
      end
      checks++;
      if ({dout1, rise1, fall1, changed1} !== {m1.dout, m1.rise, m1.fall, m1.changed}) begin
        errors++;
        $display("FAIL enable_d1 step%0d: dout=%h fall=%h expected dout=%h fall=%h", k, dout1,
                 fall1, m1.dout, m1.fall);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    din = 8'hA5;
    repeat (4) step();
    for (int k = 1; k <= 2; k++) begin
      rst = 1'b1;
      step();
      checks++;
      if ({dout4, rise4, fall4, changed4} !== '0 || rise1 !== 8'h00 || dout1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: dout=%h rise=%h fall=%h dout1=%h expected zero", k,
                 dout4, rise4, fall4, dout1);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (dout4 !== (k >= 6 ? 8'hA5 : 8'h00) || rise4 !== (k == 6 ? 8'hA5 : 8'h00) ||
          fall4 !== 8'h00 || changed4 !== (k == 6)) begin
        errors++;
        $display("FAIL post_reset edge%0d: dout=%h rise=%h chg=%b", k, dout4, rise4, changed4);
      end
    end
  endtask

  task automatic test_d1();
    rst = 1'b1; din = 8'h00;
    step();
    rst = 1'b0;
    repeat (3) step();
    din = 8'h80;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (dout1 !== (k >= 3 ? 8'h80 : 8'h00) || rise1 !== (k == 3 ? 8'h80 : 8'h00) ||
          changed1 !== (k == 3)) begin
        errors++;
        $display("FAIL d1 edge%0d: dout=%h rise=%h chg=%b", k, dout1, rise1, changed1);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(3) == 0) din = 8'($urandom);
      else if ($urandom_range(2) == 0) din = din ^ (8'h01 << $urandom_range(7));
      en  = ($urandom_range(3) != 0);
      rst = ($urandom_range(99) == 0);
      step();
      checks++;
      if ({dout4, rise4, fall4, changed4} !== {m4.dout, m4.rise, m4.fall, m4.changed} ||
          (rise4 & fall4) !== 8'h00) begin
        errors++;
        $display("FAIL random_d4 cyc%0d: dout=%h rise=%h fall=%h chg=%b exp %h %h %h %b", k,
                 dout4, rise4, fall4, changed4, m4.dout, m4.rise, m4.fall, m4.changed);
      end
      checks++;
      if ({dout1, rise1, fall1, changed1} !== {m1.dout, m1.rise, m1.fall, m1.changed}) begin
        errors++;
        $display("FAIL random_d1 cyc%0d: dout=%h rise=%h fall=%h chg=%b exp %h %h %h %b", k,
                 dout1, rise1, fall1, changed1, m1.dout, m1.rise, m1.fall, m1.changed);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m4 = '0;
    m1 = '0;
    rst = 1'b1; en = 1'b1; din = 8'h00;
    #1;
    test_reset();
    test_rise();
    test_glitch();
    test_multi();
    test_enable();
    test_reset_mid();
    test_d1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
